spi_tx_frame_feeder: RTL and testbench

//  Upstream stage of the SPI master: buffers bytes from FPGA logic in a FIFO and frames them.

---
 rtl/spi_pkg.sv | 14 +
 rtl/spi_byte_fifo.sv | 64 ++++++
 rtl/spi_tx_frame_feeder.sv | 134 +++++++++++++
 tb/tb_spi_tx_frame_feeder.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI transmit framing path.
package spi_pkg;

    localparam int BYTE_W        = 8;
    localparam int BITS_PER_BYTE = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        GAP
    } state_t;

endpackage

// File: rtl/spi_byte_fifo.sv
// Byte FIFO feeding the SPI frame FSM; occupancy is kept in an explicit count register.
module spi_byte_fifo #(
    parameter int DEPTH  = 8,
    parameter int BYTE_W = 8
) (
    input  logic                     SPI_clk,
    input  logic                     Reset,
    input  logic [BYTE_W-1:0]        wr_data,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic                     pop,
    output logic [BYTE_W-1:0]        rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [BYTE_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              do_push, do_pop;

    assign do_push = wr_valid && (count_q != FULL_CNT);
    assign do_pop  = pop && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // DEPTH is a power of two, so pointer overflow is the modulo wrap
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge SPI_clk or negedge Reset) begin
        if (!Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge SPI_clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data  = mem_q[rd_ptr_q];
    assign empty    = (count_q == '0);
    assign wr_ready = (count_q != FULL_CNT);
    assign level    = count_q;

endmodule

// File: rtl/spi_tx_frame_feeder.sv
// Frames buffered bytes for the SPI master: one CS-low burst per run of queued bytes.
module spi_tx_frame_feeder
    import spi_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int GAP_CYCLES = 2,
    parameter int MAX_BYTES  = 0
) (
    input  logic                     SPI_clk,
    input  logic                     Reset,
    input  logic [BYTE_W-1:0]        wr_data,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic                     enable,
    output logic [BYTE_W-1:0]        T_Data,
    output logic                     T_Ready,
    output logic                     Start,
    output logic                     busy,
    output logic                     frame_done,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int BW = $clog2(BITS_PER_BYTE);
    localparam logic [BW-1:0] LAST_BIT = BW'(BITS_PER_BYTE - 1);
    localparam logic [15:0]   GAP_LAST = 16'(GAP_CYCLES - 1);

    state_t            state_q, state_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [15:0]       byte_cnt_q, byte_cnt_d;
    logic [15:0]       gap_cnt_q, gap_cnt_d;
    logic [BYTE_W-1:0] t_data_q, t_data_d;
    logic              t_ready_q, t_ready_d;
    logic              start_q, start_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;
    logic              pop, fifo_empty, more_ok;
    logic [BYTE_W-1:0] head;

    spi_byte_fifo #(
        .DEPTH  (DEPTH),
        .BYTE_W (BYTE_W)
    ) u_fifo (
        .SPI_clk  (SPI_clk),
        .Reset    (Reset),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .pop      (pop),
        .rd_data  (head),
        .empty    (fifo_empty),
        .level    (level)
    );

    assign more_ok = !fifo_empty &&
                     ((MAX_BYTES == 0) || (int'({16'd0, byte_cnt_q}) < MAX_BYTES));

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        t_data_d     = t_data_q;
        t_ready_d    = 1'b0;
        frame_done_d = 1'b0;
        pop          = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && !fifo_empty) state_d = LOAD;
            end
            LOAD: begin
                pop        = 1'b1;
                t_data_d   = head;
                t_ready_d  = 1'b1;
                bit_cnt_d  = '0;
                byte_cnt_d = 16'd1;
                state_d    = SHIFT;
            end
            SHIFT: begin
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == LAST_BIT) begin
                    if (more_ok) begin
                        pop       = 1'b1;
                        t_data_d  = head;
                        t_ready_d = 1'b1;
                        if (byte_cnt_q != '1) byte_cnt_d = byte_cnt_q + 1'b1;
                    end else begin
                        state_d      = GAP;
                        gap_cnt_d    = '0;
                        frame_done_d = 1'b1;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) state_d = IDLE;
                else                       gap_cnt_d = gap_cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // Start and busy are registered from the next state so they never glitch
        start_d = (state_d != SHIFT);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge SPI_clk or negedge Reset) begin
        if (!Reset) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            byte_cnt_q   <= '0;
            gap_cnt_q    <= '0;
            t_data_q     <= '0;
            t_ready_q    <= 1'b0;
            start_q      <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            t_data_q     <= t_data_d;
            t_ready_q    <= t_ready_d;
            start_q      <= start_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign T_Data     = t_data_q;
    assign T_Ready    = t_ready_q;
    assign Start      = start_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_spi_tx_frame_feeder.sv
// Self-checking bench: instance 0 unlimited frames, instance 1 with MAX_BYTES=2.
module tb_spi_tx_frame_feeder;

    localparam int DEPTH = 8;
    localparam int GAP   = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] wr_data    [2];
    logic       wr_valid   [2];
    logic       wr_ready   [2];
    logic       enable     [2];
    logic [7:0] t_data     [2];
    logic       t_ready    [2];
    logic       start      [2];
    logic       busy       [2];
    logic       frame_done [2];
    logic [3:0] level      [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spi_tx_frame_feeder #(.DEPTH(DEPTH), .GAP_CYCLES(GAP), .MAX_BYTES(0)) u_dut0 (
        .SPI_clk(clk), .Reset(rst_n), .wr_data(wr_data[0]), .wr_valid(wr_valid[0]),
        .wr_ready(wr_ready[0]), .enable(enable[0]), .T_Data(t_data[0]), .T_Ready(t_ready[0]),
        .Start(start[0]), .busy(busy[0]), .frame_done(frame_done[0]), .level(level[0]));

    spi_tx_frame_feeder #(.DEPTH(DEPTH), .GAP_CYCLES(GAP), .MAX_BYTES(2)) u_dut1 (
        .SPI_clk(clk), .Reset(rst_n), .wr_data(wr_data[1]), .wr_valid(wr_valid[1]),
        .wr_ready(wr_ready[1]), .enable(enable[1]), .T_Data(t_data[1]), .T_Ready(t_ready[1]),
        .Start(start[1]), .busy(busy[1]), .frame_done(frame_done[1]), .level(level[1]));

    // Observed frames, collected from the pins on every falling edge
    logic [7:0] mon_bytes [2][64];
    int         mon_pos   [2][64];
    int         mon_lens  [2][16];
    int         mon_low   [2][16];
    int         mon_gaps  [2][16];
    int nbytes[2], nframes[2], ngaps[2];
    int low_cnt[2], cur_len[2], hi_cnt[2], done_cnt[2], done_rise[2], stray[2];
    bit had_frame[2];

    logic [7:0] stim[$];
    logic [7:0] exp_q[$];

    task automatic clear_mon(input int i);
        nbytes[i] = 0; nframes[i] = 0; ngaps[i] = 0; low_cnt[i] = 0; cur_len[i] = 0;
        hi_cnt[i] = 0; done_cnt[i] = 0; done_rise[i] = 0; stray[i] = 0; had_frame[i] = 0;
        exp_q.delete();
    endtask

    initial begin : monitor
        for (int i = 0; i < 2; i++) clear_mon(i);
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!rst_n) begin
                    low_cnt[i] = 0; cur_len[i] = 0; hi_cnt[i] = 0; had_frame[i] = 0;
                end else begin
                    if (frame_done[i]) done_cnt[i]++;
                    if (!start[i]) begin
                        if (low_cnt[i] == 0 && had_frame[i] && ngaps[i] < 16) begin
                            mon_gaps[i][ngaps[i]] = hi_cnt[i];
                            ngaps[i]++;
                        end
                        low_cnt[i]++;
                        if (t_ready[i] && nbytes[i] < 64) begin
                            mon_bytes[i][nbytes[i]] = t_data[i];
                            mon_pos[i][nbytes[i]]   = low_cnt[i];
                            nbytes[i]++;
                            cur_len[i]++;
                        end
                    end else begin
                        if (t_ready[i]) stray[i]++;
                        if (low_cnt[i] > 0) begin
                            if (nframes[i] < 16) begin
                                mon_lens[i][nframes[i]] = cur_len[i];
                                mon_low[i][nframes[i]]  = low_cnt[i];
                                nframes[i]++;
                            end
                            if (frame_done[i]) done_rise[i]++;
                            low_cnt[i] = 0; cur_len[i] = 0; hi_cnt[i] = 0; had_frame[i] = 1;
                        end
                        hi_cnt[i]++;
                    end
                end
            end
        end
    end

    task automatic push_list(input int i);
        for (int k = 0; k < stim.size(); k++) begin
            @(posedge clk); #1;
            wr_valid[i] = 1'b1;
            wr_data[i]  = stim[k];
            exp_q.push_back(stim[k]);
        end
        @(posedge clk); #1;
        wr_valid[i] = 1'b0;
        stim.delete();
    endtask

    task automatic fill_random(input int n);
        for (int k = 0; k < n; k++) stim.push_back(8'($urandom));
    endtask

    task automatic wait_drain(input int i, input int budget, output bit ok);
        int cnt = 0;
        while (!busy[i] && cnt < budget) begin @(negedge clk); cnt++; end
        while ((busy[i] || level[i] != 0) && cnt < budget) begin @(negedge clk); cnt++; end
        repeat (2) @(negedge clk);
        ok = (cnt < budget);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (wr_ready[i] !== 1'b1 || t_data[i] !== 8'h00 || t_ready[i] !== 1'b0 ||
                start[i] !== 1'b1 || busy[i] !== 1'b0 || frame_done[i] !== 1'b0 || level[i] !== 4'd0) begin
                errors++;
                $display("FAIL reset_values inst%0d: wr_ready=%b t_data=%h t_ready=%b start=%b busy=%b done=%b level=%0d, need 1 00 0 1 0 0 0",
                         i, wr_ready[i], t_data[i], t_ready[i], start[i], busy[i], frame_done[i], level[i]);
            end
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_byte();
        bit ok;
        clear_mon(0);
        enable[0] = 1'b1;
        stim.push_back(8'hA5);
        push_list(0);
        @(negedge clk);
        checks++;
        if (start[0] !== 1'b1 || busy[0] !== 1'b0) begin
            errors++; $display("FAIL single_n1: start=%b busy=%b, need 1 0", start[0], busy[0]);
        end
        @(negedge clk);
        checks++;
        if (start[0] !== 1'b1 || busy[0] !== 1'b1) begin
            errors++; $display("FAIL single_load: start=%b busy=%b, need 1 1", start[0], busy[0]);
        end
        @(negedge clk);
        checks++;
        if (start[0] !== 1'b0 || t_ready[0] !== 1'b1 || t_data[0] !== 8'hA5) begin
            errors++;
            $display("FAIL single_first: start=%b t_ready=%b t_data=%h, need 0 1 a5", start[0], t_ready[0], t_data[0]);
        end
        wait_drain(0, 100, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL single_timeout: drained=0, need 1"); end
        checks++;
        if (nframes[0] !== 1 || mon_lens[0][0] !== 1 || mon_low[0][0] !== 8 || mon_bytes[0][0] !== 8'hA5) begin
            errors++;
            $display("FAIL single_frame: frames=%0d len=%0d low=%0d byte=%h, need 1 1 8 a5",
                     nframes[0], mon_lens[0][0], mon_low[0][0], mon_bytes[0][0]);
        end
        checks++;
        if (done_cnt[0] !== 1 || done_rise[0] !== 1 || busy[0] !== 1'b0 || stray[0] !== 0) begin
            errors++;
            $display("FAIL single_done: done=%0d at_rise=%0d busy=%b stray=%0d, need 1 1 0 0",
                     done_cnt[0], done_rise[0], busy[0], stray[0]);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        clear_mon(0);
        enable[0] = 1'b1;
        stim.push_back(8'h11); stim.push_back(8'h22); stim.push_back(8'h33);
        push_list(0);
        wait_drain(0, 200, ok);
        checks++;
        if (!ok || nframes[0] !== 1 || mon_lens[0][0] !== 3 || mon_low[0][0] !== 24) begin
            errors++;
            $display("FAIL b2b_frame: ok=%b frames=%0d len=%0d low=%0d, need 1 1 3 24",
                     ok, nframes[0], mon_lens[0][0], mon_low[0][0]);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (mon_bytes[0][k] !== exp_q[k] || mon_pos[0][k] !== 1 + 8 * k) begin
                errors++;
                $display("FAIL b2b_byte%0d: data=%h pos=%0d, need %h %0d", k, mon_bytes[0][k], mon_pos[0][k], exp_q[k], 1 + 8 * k);
            end
        end
    endtask

    // Reference: queued bytes leave in order, split into chunks of maxb (whole run if 0)
    task automatic check_chunks(input int i, input int maxb, input string tag);
        int rem = exp_q.size();
        int f = 0;
        int b = 0;
        while (rem > 0) begin
            int len = (maxb == 0 || rem < maxb) ? rem : maxb;
            checks++;
            if (f >= nframes[i] || mon_lens[i][f] !== len || mon_low[i][f] !== 8 * len) begin
                errors++;
                $display("FAIL %s_frame%0d: frames=%0d len=%0d low=%0d, need len %0d low %0d",
                         tag, f, nframes[i], mon_lens[i][f], mon_low[i][f], len, 8 * len);
            end
            rem -= len; f++;
        end
        checks++;
        if (nframes[i] !== f || done_cnt[i] !== f || done_rise[i] !== f || stray[i] !== 0) begin
            errors++;
            $display("FAIL %s_count: frames=%0d done=%0d at_rise=%0d stray=%0d, need %0d %0d %0d 0",
                     tag, nframes[i], done_cnt[i], done_rise[i], stray[i], f, f, f);
        end
        for (b = 0; b < exp_q.size(); b++) begin
            checks++;
            if (b >= nbytes[i] || mon_bytes[i][b] !== exp_q[b]) begin
                errors++;
                $display("FAIL %s_byte%0d: got %h, need %h", tag, b, mon_bytes[i][b], exp_q[b]);
            end
        end
        for (int g = 0; g < ngaps[i]; g++) begin
            checks++;
            if (mon_gaps[i][g] < GAP) begin
                errors++; $display("FAIL %s_gap%0d: high %0d cycles, need >= %0d", tag, g, mon_gaps[i][g], GAP);
            end
        end
    endtask

    task automatic test_max_bytes();
        bit ok;
        clear_mon(1);
        enable[1] = 1'b1;
        fill_random(4);
        push_list(1);
        wait_drain(1, 300, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL max_timeout: drained=0, need 1"); end
        check_chunks(1, 2, "max");
        enable[1] = 1'b0;
    endtask

    task automatic test_full();
        bit ok;
        clear_mon(0);
        enable[0] = 1'b0;
        fill_random(9);
        for (int k = 0; k <= 9; k++) begin
            @(posedge clk); #1;
            wr_valid[0] = (k < 9);
            if (k < 9) wr_data[0] = stim[k];
            @(negedge clk);
            checks++;
            if (level[0] !== 4'((k < DEPTH) ? k : DEPTH) || wr_ready[0] !== (k < DEPTH)) begin
                errors++;
                $display("FAIL full_step%0d: level=%0d wr_ready=%b, need %0d %b",
                         k, level[0], wr_ready[0], (k < DEPTH) ? k : DEPTH, k < DEPTH);
            end
        end
        wr_valid[0] = 1'b0;
        for (int k = 0; k < DEPTH; k++) exp_q.push_back(stim[k]);
        stim.delete();
        enable[0] = 1'b1;
        wait_drain(0, 200, ok);
        checks++;
        if (!ok || level[0] !== 4'd0) begin
            errors++; $display("FAIL full_drain: ok=%b level=%0d, need 1 0", ok, level[0]);
        end
        check_chunks(0, 0, "full");
    endtask

    task automatic test_push_pop();
        bit ok;
        clear_mon(0);
        enable[0] = 1'b0;
        fill_random(4);
        push_list(0);
        enable[0] = 1'b1;
        fill_random(4);
        push_list(0);
        wait_drain(0, 200, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL pushpop_timeout: drained=0, need 1"); end
        check_chunks(0, 0, "pushpop");
    endtask

    task automatic test_reset_mid_frame();
        int cnt = 0;
        int done_before;
        clear_mon(0);
        enable[0] = 1'b0;
        fill_random(2);
        push_list(0);
        enable[0] = 1'b1;
        while (start[0] !== 1'b0 && cnt < 40) begin @(negedge clk); cnt++; end
        checks++;
        if (cnt >= 40) begin errors++; $display("FAIL rstmid_start: start never fell, need fall"); end
        repeat (3) @(negedge clk);
        done_before = done_cnt[0];
        rst_n = 1'b0;
        #1;
        checks++;
        if (start[0] !== 1'b1 || level[0] !== 4'd0 || t_ready[0] !== 1'b0 || frame_done[0] !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async: start=%b level=%0d t_ready=%b done=%b, need 1 0 0 0",
                     start[0], level[0], t_ready[0], frame_done[0]);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (busy[0] !== 1'b0 || level[0] !== 4'd0 || done_cnt[0] !== done_before || nframes[0] !== 0) begin
            errors++;
            $display("FAIL rstmid_after: busy=%b level=%0d done=%0d frames=%0d, need 0 0 %0d 0",
                     busy[0], level[0], done_cnt[0], nframes[0], done_before);
        end
    endtask

    task automatic test_enable_gate();
        bit ok;
        clear_mon(0);
        enable[0] = 1'b0;
        fill_random(3);
        push_list(0);
        repeat (10) @(negedge clk);
        checks++;
        if (start[0] !== 1'b1 || busy[0] !== 1'b0 || level[0] !== 4'd3) begin
            errors++;
            $display("FAIL gate_hold: start=%b busy=%b level=%0d, need 1 0 3", start[0], busy[0], level[0]);
        end
        @(posedge clk); #1;
        enable[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (busy[0] !== 1'b1 || start[0] !== 1'b1) begin
            errors++; $display("FAIL gate_load: busy=%b start=%b, need 1 1", busy[0], start[0]);
        end
        wait_drain(0, 200, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL gate_timeout: drained=0, need 1"); end
        check_chunks(0, 0, "gate");
    endtask

    task automatic test_random_bursts();
        bit ok;
        for (int r = 0; r < 6; r++) begin
            int i = r % 2;
            clear_mon(i);
            enable[i] = 1'b0;
            fill_random(int'($urandom_range(1, DEPTH)));
            push_list(i);
            enable[i] = 1'b1;
            wait_drain(i, 400, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL rand%0d_timeout: drained=0, need 1", r); end
            check_chunks(i, (i == 1) ? 2 : 0, "rand");
            enable[i] = 1'b0;
        end
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, need self-termination");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            wr_data[i] = '0; wr_valid[i] = 1'b0; enable[i] = 1'b0;
        end
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_max_bytes();
        test_full();
        test_push_pop();
        test_reset_mid_frame();
        test_enable_gate();
        test_random_bursts();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
